// File: rtl/bias_out_buffer.sv
// -----------------------------------------------------------------------------
// bias_out_buffer
//
// Output-side row buffer between the bias stage and the host readout port.
// Biased rows are captured on bias_valid into a DEPTH-entry circular buffer
// and drained one row per accepted rd_en into a registered rd_data/rd_valid
// pair. Occupancy (count/empty/full) and a sticky overflow flag report
// buffer state to the controller.
//
// Optional feature macro: RELU_EN
//   defined   - every signed LANE_W lane of an accepted row whose sign bit is
//               set is replaced by zero on the write path (no added latency).
//   undefined - rows are stored bit-exact.
// -----------------------------------------------------------------------------
module bias_out_buffer #(
   parameter int DATA_W = 64,
   parameter int LANE_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic [DATA_W-1:0]        bias_output,
   input  logic                     bias_valid,
   input  logic                     rd_en,
   input  logic                     clear,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int LANES = DATA_W / LANE_W;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   // Storage and state
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   // Datapath / control
   logic [DATA_W-1:0] w_wr_row;
   logic              w_empty;
   logic              w_full;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_drop;

   // Status is decoded from the registered occupancy count only.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);

   // A read needs a stored row; an empty buffer never falls through, so a
   // same-cycle write cannot satisfy a read. A full buffer may still accept a
   // write if a read frees a slot in the same cycle. clear suppresses both.
   assign w_rd_acc = rd_en && !w_empty && !clear;
   assign w_wr_acc = bias_valid && (!w_full || w_rd_acc) && !clear;
   assign w_drop   = bias_valid && w_full && !w_rd_acc && !clear;

`ifdef RELU_EN
   // Zero every negative lane of the incoming row before it is stored.
   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
      w_wr_row = bias_output;
      for (int i = 0; i < LANES; i++) begin
         if (bias_output[i*LANE_W + LANE_W - 1]) begin
            w_wr_row[i*LANE_W +: LANE_W] = '0;
         end
      end
   end
`else
   assign w_wr_row = bias_output;
`endif

   // Row storage: written on accepted writes, never reset.
   // NOTE: the memory array is deliberately left out of reset so it maps onto plain storage cells; stale contents are unreachable because pointers/count are reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= w_wr_row;
      end
   end

   // Pointer, occupancy and sticky-overflow bookkeeping.
   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!n_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Registered read port: rd_data holds between reads and across clear.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign empty    = w_empty;
   assign full     = w_full;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: doc/bias_out_buffer.md
# bias_out_buffer

Output-side buffer that receives the 64-bit biased result rows produced by the bias stage and holds them until the host reads them. It sits between the bias stage and the host/readout interface. Each row is captured on a valid strobe into a small FIFO and drained one row per read request. Occupancy and overflow status are reported to the controller.

## Interface
Parameters:
- DATA_W, 64, row width in bits; must be a multiple of LANE_W.
- LANE_W, 8, lane width in bits; lanes are signed two's complement.
- DEPTH, 8, number of stored rows; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, asynchronous and active-low.
- bias_output  input  DATA_W  biased row from the bias stage.
- bias_valid  input  1  bias_output holds a valid row this cycle.
- rd_en  input  1  host read request.
- clear  input  1  synchronous flush.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  rd_data is valid this cycle (one-cycle pulse per accepted read).
- empty  output  1  no rows stored.
- full  output  1  DEPTH rows stored.
- count  output  $clog2(DEPTH)+1  number of rows stored.
- overflow  output  1  sticky flag: a row was dropped.

## Operation
- Storage is a circular buffer of DEPTH rows with write and read pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- Write is accepted when bias_valid=1 and either (not full) or (full and a read is accepted in the same cycle). An accepted write stores the (optionally ReLU'd) row at wr_ptr and increments wr_ptr.
- Read is accepted when rd_en=1 and not empty. An accepted read loads rd_data from mem[rd_ptr], increments rd_ptr, and pulses rd_valid on the next cycle.
- Empty buffer with simultaneous write and read: the write is accepted and the read is ignored. There is no fall-through; rd_valid stays 0.
- Full buffer with simultaneous write and read: both are accepted and count is unchanged.
- Dropped write: bias_valid=1, full=1 and no read accepted. The row is discarded and overflow is set, staying set until clear or reset.
- count: +1 on a write only, -1 on a read only, unchanged on both or neither.
- empty = (count==0); full = (count==DEPTH). Both are derived from registered count.
- clear has priority over everything in the same cycle:
  - Pointers and count go to 0 and overflow goes to 0.
  - rd_valid goes to 0 next cycle; a concurrent write and read are both ignored.
  - rd_data holds its previous value.
- rd_data holds its last value when no read is accepted.
- Memory contents are not reset.

## Timing
- Reset values: rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0; pointers are 0.
- Write latency: a row accepted at edge N is visible in count/empty after edge N. It is readable by an rd_en asserted in the cycle after edge N.
- Read latency: rd_en accepted at edge N gives rd_data/rd_valid valid after edge N, i.e. 1 cycle.
- Back-to-back reads every cycle are supported at full throughput.
- Reset asserted mid-operation immediately forces all reset values; any stored rows are lost.

## Configuration
- RELU_EN defined: each LANE_W lane of an accepted row with its sign bit set is replaced by 0 before storage. Non-negative lanes pass unchanged. The conversion is combinational on the write path and adds no latency.
- RELU_EN undefined: rows are stored bit-exact.

## Test plan
- Reset: hold n_rst=0 for 2 cycles, then release -> count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0.
- Single row: write 0xEFBECF00CBE2CBE2 and read the next cycle -> with RELU_EN undefined, rd_data=0xEFBECF00CBE2CBE2 and rd_valid high for one cycle; with RELU_EN defined, rd_data=0x0000000000000000.
- ReLU mixed lanes (RELU_EN defined): write 0x7F800001FF100000 -> read returns 0x7F00000100100000.
- Fill and overflow:
  - Write 8 rows 0x01..0x08 -> full=1 and count=8.
  - A 9th write of 0x09 without a read -> overflow=1 and count=8.
  - Draining -> 0x01..0x08 in order, then empty=1.
- Full with simultaneous read and write:
  - Start from full holding 0x01..0x08, then write 0xAA with rd_en=1 -> read returns 0x01, count stays 8, overflow stays 0.
  - Draining -> 0x02..0x08, 0xAA, which exercises pointer wrap.
- Clear: with 3 rows stored and overflow=1, assert clear together with bias_valid and rd_en -> next cycle count=0, empty=1, overflow=0, rd_valid=0, and the concurrent row is not stored.
